passcode_ctrl: RTL and testbench
================================

Name: passcode_ctrl

Overview:
- Parametrised passcode store-and-verify controller for the door lock.
- Captures keypad digits into an entry buffer and compares them against a stored code of variable length.
- Drives open, lockout and set-code status toward the lock actuator and UI logic.
- Adds these modes: code change while open, failed-attempt lockout and auto-close timeout.

Parameters:
- DIGIT_W, 4, bits per keypad digit.
- MAX_LEN, 6, maximum code length in digits.
- MIN_LEN, 4, minimum code length accepted when setting a code.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout.
- LOCK_CYCLES, 1000, lockout duration in clk_i cycles.
- OPEN_CYCLES, 500, auto-close timeout in OPEN, in clk_i cycles.

Ports:
- clk_i, input, 1, system clock; all state changes on rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- digit_i, input, DIGIT_W, keypad digit value.
- digit_vld_i, input, 1, digit_i valid this cycle (one digit per asserted cycle).
- enter_i, input, 1, terminate entry and evaluate.
- clear_i, input, 1, discard current entry.
- set_req_i, input, 1, request code change (honoured in OPEN only).
- close_i, input, 1, close door from OPEN.
- open_o, output, 1, level: door unlocked (state OPEN).
- corr_o, output, 1, 1-cycle pulse: code matched.
- fail_o, output, 1, 1-cycle pulse: code mismatched.
- set_o, output, 1, 1-cycle pulse: new code committed.
- set_err_o, output, 1, 1-cycle pulse: new code rejected (bad length).
- locked_o, output, 1, level: lockout active.
- fail_cnt_o, output, $clog2(MAX_FAIL+1), consecutive failure count.

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; all outputs 0.
  - Entry buffer and count cleared; fail count 0; timers 0.
  - Stored code is MIN_LEN digits, all zero.
- States: IDLE, ENTRY, OPEN, SET, LOCKED. All outputs are registered; pulses appear the cycle after the triggering input is sampled.
- Input priority within one cycle: clear_i > enter_i > digit_vld_i.
  - When enter_i and digit_vld_i are both high, the digit is appended first and the evaluation includes it.
- IDLE:
  - digit_vld_i: write buffer[0], count=1, go to ENTRY.
  - enter_i with no digits: treated as an empty-code mismatch.
  - clear_i: no effect.
- ENTRY:
  - digit_vld_i with count<MAX_LEN: write buffer[count], count++.
  - digit_vld_i with count==MAX_LEN: digit dropped (no wrap); overflow flag set.
  - clear_i: go to IDLE; buffer discarded; fail count unchanged.
  - enter_i: match iff count==stored_len, no overflow, and buffer[0..count-1]==stored[0..count-1].
    - Match: corr_o pulse, fail count=0, go to OPEN, load open timer=OPEN_CYCLES.
    - Mismatch: fail_o pulse, fail count++. If the new count==MAX_FAIL: go to LOCKED, load lock timer=LOCK_CYCLES, locked_o=1. Else go to IDLE.
- OPEN:
  - open_o=1; timer decrements each cycle.
  - close_i or timer reaching 0: go to IDLE, open_o=0.
  - set_req_i (priority over close_i): go to SET with count=0, overflow cleared. open_o stays 1 and the timer is frozen while in SET.
- SET:
  - Digit capture is identical to ENTRY.
  - enter_i with MIN_LEN<=count<=MAX_LEN and no overflow: copy buffer to stored code, stored_len=count, set_o pulse, go to IDLE (door closes).
  - enter_i otherwise: set_err_o pulse, stored code unchanged, return to OPEN, timer reloaded.
  - clear_i: return to OPEN, timer reloaded, no pulse.
- LOCKED:
  - All inputs ignored; the timer decrements.
  - When the timer reaches 0: go to IDLE, locked_o=0, fail count=0.
- Entry buffer is cleared on every transition into IDLE.
- Reset asserted mid-operation restores the reset state immediately, including the stored code.

Test Plan:
- Reset, enter 0,0,0,0 then enter_i -> corr_o pulses once, open_o=1; after 500 cycles with no input, open_o=0 and state is IDLE.
- Reset, enter 1,2,3,4 -> fail_o, fail_cnt_o=1. Repeat twice -> third failure sets locked_o=1, and digits entered during lockout are ignored. After 1000 cycles, locked_o=0 and fail_cnt_o=0.
- Open with 0,0,0,0, set_req_i, enter 9,8,7,6,5 then enter_i -> set_o pulses, state IDLE. Entering 0,0,0,0 now fails; entering 9,8,7,6,5 gives corr_o.
- In SET, enter 1,2,3 then enter_i -> set_err_o, open_o still 1, old code still valid. Entering 7 digits -> overflow, set_err_o.
- Enter 0,0,0 then pulse clear_i, then 0,0,0,0 -> corr_o with no fail_o.
- Enter 0,0,0 with the 4th digit 0 presented on the same cycle as enter_i -> corr_o.
- Assert rst_i mid-ENTRY after a code change -> all outputs 0, and the default 0,0,0,0 code opens the door.

Source files
------------

// File: rtl/passcode_ctrl.sv
// passcode_ctrl: keypad passcode store-and-verify controller for the door lock.
// Handles entry, code change while open, failed-attempt lockout and auto-close.
module passcode_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int MAX_LEN     = 6,
    parameter int MIN_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int OPEN_CYCLES = 500
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DIGIT_W-1:0]              digit_i,
    input  logic                            digit_vld_i,
    input  logic                            enter_i,
    input  logic                            clear_i,
    input  logic                            set_req_i,
    input  logic                            close_i,
    output logic                            open_o,
    output logic                            corr_o,
    output logic                            fail_o,
    output logic                            set_o,
    output logic                            set_err_o,
    output logic                            locked_o,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt_o
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_SET,
        S_LOCKED
    } state_t;

    state_t                          state_q;
    logic [MAX_LEN-1:0][DIGIT_W-1:0] buf_q;
    logic [LW-1:0]                   cnt_q;
    logic                            ovf_q;
    logic [MAX_LEN-1:0][DIGIT_W-1:0] code_q;
    logic [LW-1:0]                   code_len_q;
    logic [FW-1:0]                   fail_q;
    logic [TW-1:0]                   timer_q;
    logic                            open_q;
    logic                            corr_q;
    logic                            fail_p_q;
    logic                            set_q;
    logic                            set_err_q;
    logic                            locked_q;

    logic [MAX_LEN-1:0][DIGIT_W-1:0] buf_d;
    logic [LW-1:0]                   cnt_d;
    logic                            ovf_d;
    logic                            match;
    logic [FW-1:0]                   fail_inc;

    // Buffer as it would look with this cycle's digit appended, and its
    // comparison against the stored code (so enter+digit includes the digit).
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (digit_vld_i) begin
            if (cnt_q < LW'(MAX_LEN)) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LW'(i) == cnt_q) begin
                        buf_d[i] = digit_i;
                    end
                end
                cnt_d = cnt_q + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        match = (cnt_d == code_len_q) && !ovf_d;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < cnt_d) && (buf_d[i] != code_q[i])) begin
                match = 1'b0;
            end
        end
        fail_inc = fail_q + FW'(1);
    end

    // Main controller FSM with registered status outputs and pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            code_q     <= '0;
            code_len_q <= LW'(MIN_LEN);
            fail_q     <= '0;
            timer_q    <= '0;
            open_q     <= 1'b0;
            corr_q     <= 1'b0;
            fail_p_q   <= 1'b0;
            set_q      <= 1'b0;
            set_err_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            corr_q    <= 1'b0;
            fail_p_q  <= 1'b0;
            set_q     <= 1'b0;
            set_err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (clear_i) begin
                        state_q <= S_IDLE;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (enter_i) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        if (match) begin
                            corr_q  <= 1'b1;
                            fail_q  <= '0;
                            state_q <= S_OPEN;
                            timer_q <= TW'(OPEN_CYCLES);
                            open_q  <= 1'b1;
                        end else begin
                            fail_p_q <= 1'b1;
                            fail_q   <= fail_inc;
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                state_q  <= S_LOCKED;
                                timer_q  <= TW'(LOCK_CYCLES);
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end else if (digit_vld_i) begin
                        buf_q   <= buf_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        state_q <= S_ENTRY;
                    end
                end
                S_OPEN: begin
                    if (set_req_i) begin
                        state_q <= S_SET;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (close_i || (timer_q <= TW'(1))) begin
                        state_q <= S_IDLE;
                        open_q  <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_SET: begin
                    if (clear_i) begin
                        state_q <= S_OPEN;
                        timer_q <= TW'(OPEN_CYCLES);
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (enter_i) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        if ((cnt_d >= LW'(MIN_LEN)) && !ovf_d) begin
                            code_q     <= buf_d;
                            code_len_q <= cnt_d;
                            set_q      <= 1'b1;
                            state_q    <= S_IDLE;
                            open_q     <= 1'b0;
                            timer_q    <= '0;
                        end else begin
                            set_err_q <= 1'b1;
                            state_q   <= S_OPEN;
                            timer_q   <= TW'(OPEN_CYCLES);
                        end
                    end else if (digit_vld_i) begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                    end
                end
                S_LOCKED: begin
                    if (timer_q <= TW'(1)) begin
                        state_q  <= S_IDLE;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign open_o     = open_q;
    assign corr_o     = corr_q;
    assign fail_o     = fail_p_q;
    assign set_o      = set_q;
    assign set_err_o  = set_err_q;
    assign locked_o   = locked_q;
    assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_passcode_ctrl.sv
// tb_passcode_ctrl: directed bench for passcode_ctrl.
// Expected pulses are queued at stimulus time and popped as the DUT emits them.
module tb_passcode_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] digit_i;
    logic       digit_vld_i;
    logic       enter_i;
    logic       clear_i;
    logic       set_req_i;
    logic       close_i;
    logic       open_o;
    logic       corr_o;
    logic       fail_o;
    logic       set_o;
    logic       set_err_o;
    logic       locked_o;
    logic [1:0] fail_cnt_o;

    localparam logic [3:0] P_CORR = 4'b1000;
    localparam logic [3:0] P_FAIL = 4'b0100;
    localparam logic [3:0] P_SET  = 4'b0010;
    localparam logic [3:0] P_SERR = 4'b0001;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [3:0] sb[$];
    logic [3:0] pv;
    logic [3:0] pexp;

    passcode_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .digit_i     (digit_i),
        .digit_vld_i (digit_vld_i),
        .enter_i     (enter_i),
        .clear_i     (clear_i),
        .set_req_i   (set_req_i),
        .close_i     (close_i),
        .open_o      (open_o),
        .corr_o      (corr_o),
        .fail_o      (fail_o),
        .set_o       (set_o),
        .set_err_o   (set_err_o),
        .locked_o    (locked_o),
        .fail_cnt_o  (fail_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Pulse monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        pv = {corr_o, fail_o, set_o, set_err_o};
        if (pv !== 4'b0000) begin
            pexp = (sb.size() > 0) ? sb.pop_front() : 4'b0000;
            total++;
            assert (pv === pexp) passed++;
            else begin
                failed++;
                $error("FAIL pulse: observed %b, expected %b", pv, pexp);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic vld, input logic ent,
                         input logic clr, input logic sreq, input logic cls);
        digit_i     = d;
        digit_vld_i = vld;
        enter_i     = ent;
        clear_i     = clr;
        set_req_i   = sreq;
        close_i     = cls;
        @(negedge clk);
        digit_vld_i = 1'b0;
        enter_i     = 1'b0;
        clear_i     = 1'b0;
        set_req_i   = 1'b0;
        close_i     = 1'b0;
    endtask

    task automatic keys(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            drive(v[4*(n-1-i) +: 4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic enter_exp(input string tag, input logic [3:0] exp);
        sb.push_back(exp);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        digit_i     = 4'h0;
        digit_vld_i = 1'b0;
        enter_i     = 1'b0;
        clear_i     = 1'b0;
        set_req_i   = 1'b0;
        close_i     = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
    endtask

    initial begin
        do_reset();
        chk("rst_open", open_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_failcnt", fail_cnt_o, 0);
        chk("rst_pulses", {corr_o, fail_o, set_o, set_err_o}, 0);

        // Default code opens; auto-close after OPEN_CYCLES
        keys(32'h0000, 4);
        enter_exp("t1_corr", P_CORR);
        chk("t1_open", open_o, 1);
        repeat (499) @(negedge clk);
        chk("t1_open_499", open_o, 1);
        @(negedge clk);
        chk("t1_closed_500", open_o, 0);
        keys(32'h0000, 4);
        enter_exp("t1_reopen", P_CORR);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_close_i", open_o, 0);

        // Empty entry fails; clear in IDLE harmless
        enter_exp("t1b_empty", P_FAIL);
        chk("t1b_failcnt", fail_cnt_o, 1);
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        keys(32'h0000, 4);
        enter_exp("t1b_corr", P_CORR);
        chk("t1b_failcnt0", fail_cnt_o, 0);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Lockout after three failures
        do_reset();
        keys(32'h1234, 4);
        enter_exp("t2_fail1", P_FAIL);
        chk("t2_cnt1", fail_cnt_o, 1);
        keys(32'h1234, 4);
        enter_exp("t2_fail2", P_FAIL);
        chk("t2_cnt2", fail_cnt_o, 2);
        chk("t2_unlocked", locked_o, 0);
        keys(32'h1234, 4);
        enter_exp("t2_fail3", P_FAIL);
        chk("t2_locked", locked_o, 1);
        chk("t2_cnt3", fail_cnt_o, 3);
        keys(32'h0000, 4);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ignored_open", open_o, 0);
        repeat (994) @(negedge clk);
        chk("t2_locked_999", locked_o, 1);
        @(negedge clk);
        chk("t2_unlocked_1000", locked_o, 0);
        chk("t2_cnt_cleared", fail_cnt_o, 0);
        keys(32'h0000, 4);
        enter_exp("t2_after_corr", P_CORR);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Code change to 98765
        do_reset();
        keys(32'h0000, 4);
        enter_exp("t3_corr", P_CORR);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_set_open", open_o, 1);
        keys(32'h98765, 5);
        enter_exp("t3_set", P_SET);
        chk("t3_closed", open_o, 0);
        keys(32'h0000, 4);
        enter_exp("t3_old_fails", P_FAIL);
        keys(32'h98765, 5);
        enter_exp("t3_new_corr", P_CORR);
        chk("t3_cnt0", fail_cnt_o, 0);

        // Bad-length codes rejected; clear in SET returns to OPEN
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        keys(32'h123, 3);
        enter_exp("t4_short", P_SERR);
        chk("t4_open_short", open_o, 1);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        keys(32'h1234567, 7);
        enter_exp("t4_ovf", P_SERR);
        chk("t4_open_ovf", open_o, 1);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        keys(32'h5, 1);
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_clear_open", open_o, 1);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_closed", open_o, 0);
        keys(32'h98765, 5);
        enter_exp("t4_old_valid", P_CORR);

        // MAX_LEN code accepted
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        keys(32'h123456, 6);
        enter_exp("t4_set6", P_SET);
        keys(32'h123456, 6);
        enter_exp("t4_corr6", P_CORR);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        keys(32'h12345, 5);
        enter_exp("t4_prefix_fail", P_FAIL);
        chk("t4_cnt1", fail_cnt_o, 1);

        // Async reset mid-entry restores default code
        keys(32'h12, 2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t7_open", open_o, 0);
        chk("t7_locked", locked_o, 0);
        chk("t7_failcnt", fail_cnt_o, 0);
        chk("t7_pulses", {corr_o, fail_o, set_o, set_err_o}, 0);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        keys(32'h0000, 4);
        enter_exp("t7_default", P_CORR);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear mid-entry
        keys(32'h000, 3);
        drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        keys(32'h0000, 4);
        enter_exp("t5_corr", P_CORR);
        chk("t5_cnt0", fail_cnt_o, 0);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Last digit on the same cycle as enter
        keys(32'h000, 3);
        sb.push_back(P_CORR);
        drive(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t6_same_cycle", sb.size(), 0);
        chk("t6_open", open_o, 1);

        repeat (3) @(negedge clk);
        chk("end_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
